// File: rtl/add_tile_stream.sv
`default_nettype none
// ============================================================================
// Module      : add_tile_stream
// Description : Accepts a valid/ready stream of operand pairs, adds each pair
//               and packs the sums row-major into a 4x4 staging tile. A beat
//               flagged in_last before the 16th element ends the tile early;
//               the remaining elements are zero-filled one per cycle. The
//               completed tile is held on o11..o44 with out_load asserted
//               until out_ready accepts it.
//               Optional build macro ADD_SAT_EN: operands are treated as
//               two's-complement and sums saturate to the signed max/min
//               instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module add_tile_stream #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_load,
    input  logic             out_ready,
    output logic             tile_short,
    output logic [WIDTH-1:0] o11,
    output logic [WIDTH-1:0] o12,
    output logic [WIDTH-1:0] o13,
    output logic [WIDTH-1:0] o14,
    output logic [WIDTH-1:0] o21,
    output logic [WIDTH-1:0] o22,
    output logic [WIDTH-1:0] o23,
    output logic [WIDTH-1:0] o24,
    output logic [WIDTH-1:0] o31,
    output logic [WIDTH-1:0] o32,
    output logic [WIDTH-1:0] o33,
    output logic [WIDTH-1:0] o34,
    output logic [WIDTH-1:0] o41,
    output logic [WIDTH-1:0] o42,
    output logic [WIDTH-1:0] o43,
    output logic [WIDTH-1:0] o44
);

    localparam logic [1:0] c_FILL = 2'd0;
    localparam logic [1:0] c_PAD  = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;

    localparam logic [3:0] c_LAST_IDX = 4'd15;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [3:0]       r_idx;
    logic             r_short;
    logic [WIDTH-1:0] r_tile [16];
    logic [WIDTH-1:0] w_sum;
    logic             w_accept;

    assign w_accept = in_valid & in_ready;

`ifdef ADD_SAT_EN
    localparam logic [WIDTH-1:0] c_SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] w_raw_sum;
    logic             w_ovf;

    assign w_raw_sum = in_a + in_b;
    // Signed overflow: operands share a sign that the wrapped sum does not.
    assign w_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                   (w_raw_sum[WIDTH-1] != in_a[WIDTH-1]);

    // Clamp toward the operands' sign when the signed sum overflows.
    always_comb begin
        w_sum = w_raw_sum;
        if (w_ovf) begin
            w_sum = in_a[WIDTH-1] ? c_SMIN : c_SMAX;
        end
    end
`else
    // Modulo 2^WIDTH sum; carry out is dropped.
    assign w_sum = in_a + in_b;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: fill until the 16th beat or an early last, pad to the end,
    // then hold until the tile is taken.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_FILL: begin
                if (w_accept) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_next_state = c_HOLD;
                    end else if (in_last) begin
                        w_next_state = c_PAD;
                    end
                end
            end
            c_PAD: begin
                if (r_idx == c_LAST_IDX) begin
                    w_next_state = c_HOLD;
                end
            end
            c_HOLD: begin
                if (out_ready) begin
                    w_next_state = c_FILL;
                end
            end
            default: w_next_state = c_FILL;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        in_ready = 1'b0;
        out_load = 1'b0;
        case (r_state)
            c_FILL:  in_ready = 1'b1;
            c_HOLD:  out_load = 1'b1;
            default: ;
        endcase
    end

    // Tile storage, element index and short-tile flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= 4'd0;
            r_short <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_tile[i] <= '0;
            end
        end else begin
            case (r_state)
                c_FILL: begin
                    if (w_accept) begin
                        r_tile[r_idx] <= w_sum;
                        r_idx         <= r_idx + 4'd1;
                        if (in_last && (r_idx != c_LAST_IDX)) begin
                            r_short <= 1'b1;
                        end
                    end
                end
                c_PAD: begin
                    r_tile[r_idx] <= '0;
                    r_idx         <= r_idx + 4'd1;
                end
                c_HOLD: begin
                    if (out_ready) begin
                        r_idx   <= 4'd0;
                        r_short <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tile_short = r_short;

    assign o11 = r_tile[0];
    assign o12 = r_tile[1];
    assign o13 = r_tile[2];
    assign o14 = r_tile[3];
    assign o21 = r_tile[4];
    assign o22 = r_tile[5];
    assign o23 = r_tile[6];
    assign o24 = r_tile[7];
    assign o31 = r_tile[8];
    assign o32 = r_tile[9];
    assign o33 = r_tile[10];
    assign o34 = r_tile[11];
    assign o41 = r_tile[12];
    assign o42 = r_tile[13];
    assign o43 = r_tile[14];
    assign o44 = r_tile[15];

endmodule
`default_nettype wire

// File: tb/tb_add_tile_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_tile_stream
// Description : Self-checking bench for add_tile_stream: table vectors for
//               fixed sums, random tiles against a tile-level model, and
//               hand-written reset / pad / backpressure sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_tile_stream;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_last;
    logic         out_load;
    logic         out_ready;
    logic         tile_short;
    logic [W-1:0] o11, o12, o13, o14, o21, o22, o23, o24;
    logic [W-1:0] o31, o32, o33, o34, o41, o42, o43, o44;
    logic [W-1:0] ot [16];

    int errors = 0;
    int checks = 0;

    logic [W-1:0] ta [16];
    logic [W-1:0] tb_op [16];
    logic [W-1:0] te [16];

    vec_t full_tbl [16];
    vec_t ovf_tbl  [6];

    add_tile_stream #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_load(out_load), .out_ready(out_ready), .tile_short(tile_short),
        .o11(o11), .o12(o12), .o13(o13), .o14(o14),
        .o21(o21), .o22(o22), .o23(o23), .o24(o24),
        .o31(o31), .o32(o32), .o33(o33), .o34(o34),
        .o41(o41), .o42(o42), .o43(o43), .o44(o44)
    );

    always #5 clk = ~clk;

    always_comb begin
        ot[0]  = o11; ot[1]  = o12; ot[2]  = o13; ot[3]  = o14;
        ot[4]  = o21; ot[5]  = o22; ot[6]  = o23; ot[7]  = o24;
        ot[8]  = o31; ot[9]  = o32; ot[10] = o33; ot[11] = o34;
        ot[12] = o41; ot[13] = o42; ot[14] = o43; ot[15] = o44;
    end

    // Reference sum from the arithmetic rules, not the RTL structure.
    function automatic logic [W-1:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ADD_SAT_EN
        longint s, mx, mn;
        s  = longint'($signed(a)) + longint'($signed(b));
        mx = (longint'(1) <<< (W - 1)) - 1;
        mn = -mx - 1;
        if (s > mx) s = mx;
        if (s < mn) s = mn;
        return s[W-1:0];
`else
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W-1:0];
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_tile(input string tag, input logic exp_short);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s elem%0d", tag, i), 64'(ot[i]), 64'(te[i]));
        end
        check({tag, " tile_short"}, 64'(tile_short), 64'(exp_short));
    endtask

    // Expected tile for n beats: model sums, remaining elements zero.
    task automatic build_expect(input int n);
        for (int i = 0; i < 16; i++) begin
            te[i] = (i < n) ? model_add(ta[i], tb_op[i]) : '0;
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return {W{1'b1}};
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    // Send an n-beat tile from ta/tb_op, check pad length, held tile,
    // backpressure for 'hold' cycles and the return to FILL.
    task automatic run_tile(input string tag, input int n, input int hold, input bit bubbles);
        int cyc;
        out_ready = (hold == 0);
        for (int i = 0; i < n; i++) begin
            if (bubbles && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_a     = W'($urandom);
                in_b     = W'($urandom);
                in_last  = 1'b1;
                tick();
            end
            check({tag, " in_ready during fill"}, 64'(in_ready), 64'(1));
            in_valid = 1'b1;
            in_a     = ta[i];
            in_b     = tb_op[i];
            in_last  = (i == n - 1);
            if (i == 15) in_last = 1'($urandom_range(0, 1));
            tick();
        end
        // Beats offered while not ready must be ignored.
        in_valid = 1'b1;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_last  = 1'($urandom_range(0, 1));
        cyc = 0;
        while (!out_load && cyc < 40) begin
            check({tag, " in_ready during pad"}, 64'(in_ready), 64'(0));
            tick();
            cyc++;
        end
        check({tag, " pad cycles"}, 64'(cyc), 64'(16 - n));
        check({tag, " out_load"}, 64'(out_load), 64'(1));
        check({tag, " in_ready in hold"}, 64'(in_ready), 64'(0));
        check_tile(tag, n < 16);
        for (int h = 0; h < hold; h++) begin
            in_a = W'($urandom);
            in_b = W'($urandom);
            tick();
            check({tag, " out_load held"}, 64'(out_load), 64'(1));
            check({tag, " in_ready held"}, 64'(in_ready), 64'(0));
        end
        if (hold > 0) check_tile({tag, " after hold"}, n < 16);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, " out_load after handoff"}, 64'(out_load), 64'(0));
        check({tag, " in_ready after handoff"}, 64'(in_ready), 64'(1));
        check({tag, " tile_short after handoff"}, 64'(tile_short), 64'(0));
    endtask

    // Push n random beats without checking; optional in_last on the final one.
    task automatic feed(input int n, input bit last);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_last  = last && (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Assert reset between clock edges and check it acts immediately.
    task automatic async_reset(input string tag);
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) te[i] = '0;
        check_tile({tag, " async"}, 1'b0);
        check({tag, " out_load async"}, 64'(out_load), 64'(0));
        #2 rst = 1'b0;
        in_valid = 1'b0;
        tick();
        check({tag, " in_ready after reset"}, 64'(in_ready), 64'(1));
        check({tag, " out_load after reset"}, 64'(out_load), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 16; k++) begin
            full_tbl[k].a = W'(k);
            full_tbl[k].b = W'(100);
            full_tbl[k].e = W'(100 + k);
        end
`ifdef ADD_SAT_EN
        ovf_tbl[0] = '{32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF};
        ovf_tbl[1] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        ovf_tbl[2] = '{32'h80000000, 32'h80000000, 32'h80000000};
        ovf_tbl[3] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
        ovf_tbl[4] = '{32'hFFFFFFFF, 32'h00000002, 32'h00000001};
        ovf_tbl[5] = '{32'h00000005, 32'hFFFFFFFD, 32'h00000002};
`else
        ovf_tbl[0] = '{32'hFFFFFFFF, 32'h00000002, 32'h00000001};
        ovf_tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 32'h80000000};
        ovf_tbl[2] = '{32'h80000000, 32'h80000000, 32'h00000000};
        ovf_tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        ovf_tbl[4] = '{32'h12345678, 32'h11111111, 32'h23456789};
        ovf_tbl[5] = '{32'h00000005, 32'hFFFFFFFD, 32'h00000002};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 16; i++) te[i] = '0;
        check_tile("reset", 1'b0);
        check("reset out_load", 64'(out_load), 64'(0));
        rst = 1'b0;
        tick();
        check("reset in_ready", 64'(in_ready), 64'(1));

        // Full tile from table: a=k, b=100.
        for (int i = 0; i < 16; i++) begin
            ta[i] = full_tbl[i].a; tb_op[i] = full_tbl[i].b; te[i] = full_tbl[i].e;
        end
        run_tile("full", 16, 0, 1'b0);

        // Overflow table as a 6-beat short tile, padded with zeros.
        for (int i = 0; i < 16; i++) begin
            ta[i] = '0; tb_op[i] = '0; te[i] = '0;
        end
        for (int i = 0; i < 6; i++) begin
            ta[i] = ovf_tbl[i].a; tb_op[i] = ovf_tbl[i].b; te[i] = ovf_tbl[i].e;
        end
        run_tile("ovf", 6, 0, 1'b0);

        // Short tile: 5 beats of 1+1 then 11 pad cycles.
        for (int i = 0; i < 16; i++) begin
            ta[i] = W'(1); tb_op[i] = W'(1); te[i] = (i < 5) ? W'(2) : W'(0);
        end
        run_tile("short", 5, 0, 1'b0);

        // Backpressure: three cycles of out_ready=0 on a random full tile.
        for (int i = 0; i < 16; i++) begin
            ta[i] = rand_operand(); tb_op[i] = rand_operand();
        end
        build_expect(16);
        run_tile("backpressure", 16, 3, 1'b1);

        // Single-beat tile: 15 pad cycles.
        ta[0] = W'($urandom); tb_op[0] = W'($urandom);
        build_expect(1);
        run_tile("one_beat", 1, 1, 1'b0);

        // Reset mid-fill after 7 beats, then a clean full tile.
        feed(7, 1'b0);
        async_reset("mid_fill");
        for (int i = 0; i < 16; i++) begin
            ta[i] = W'($urandom); tb_op[i] = W'($urandom);
        end
        build_expect(16);
        run_tile("post_reset", 16, 0, 1'b1);

        // Reset mid-pad and mid-hold.
        feed(3, 1'b1);
        tick();
        async_reset("mid_pad");
        feed(16, 1'b0);
        tick();
        async_reset("mid_hold");

        // Random tiles of random length and hold.
        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(1, 16);
            for (int i = 0; i < 16; i++) begin
                ta[i] = rand_operand(); tb_op[i] = rand_operand();
            end
            build_expect(n);
            run_tile($sformatf("rand%0d", t), n, $urandom_range(0, 2), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
